// File: rtl/leglite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leglite_pkg
// Description : Shared definitions for the LEGLite core: sequencer state
//               codes, opcode constants, ALU operation encodings and the
//               instruction class used by the controller and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package leglite_pkg;

    // Sequencer states; codes 5..7 are never entered.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Opcode field ir[15:13]
    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_AND  = 3'b010;
    localparam logic [2:0] C_OP_OR   = 3'b011;
    localparam logic [2:0] C_OP_ADDI = 3'b100;
    localparam logic [2:0] C_OP_LD   = 3'b101;
    localparam logic [2:0] C_OP_ST   = 3'b110;
    localparam logic [2:0] C_OP_CBZ  = 3'b111;

    // ALU operation encodings
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;

    // Instruction class steering the sequencer after EXEC
    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LD  = 2'd1,
        CLS_ST  = 2'd2,
        CLS_CBZ = 2'd3
    } iclass_t;

endpackage
`default_nettype wire

// File: rtl/leglite_decode.sv
`default_nettype none
// ============================================================================
// Module      : leglite_decode
// Description : Pure combinational opcode decoder.
// Ports       : i_opcode     - ir[15:13]
//               o_alu_op     - ALU operation select
//               o_alu_src    - 1 selects the sign-extended immediate
//               o_mem_to_reg - write-back source is memory (LD)
//               o_class      - instruction class for the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
module leglite_decode
    import leglite_pkg::*;
(
    input  logic [2:0] i_opcode,
    output logic [2:0] o_alu_op,
    output logic       o_alu_src,
    output logic       o_mem_to_reg,
    output iclass_t    o_class
);

    always_comb begin
        o_alu_op     = C_ALU_ADD;
        o_alu_src    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_class      = CLS_ALU;
        case (i_opcode)
            C_OP_ADD:  o_alu_op = C_ALU_ADD;
            C_OP_SUB:  o_alu_op = C_ALU_SUB;
            C_OP_AND:  o_alu_op = C_ALU_AND;
            C_OP_OR:   o_alu_op = C_ALU_OR;
            C_OP_ADDI: o_alu_src = 1'b1;
            C_OP_LD: begin
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
                o_class      = CLS_LD;
            end
            C_OP_ST: begin
                o_alu_src = 1'b1;
                o_class   = CLS_ST;
            end
            C_OP_CBZ: begin
                // Zero test is done as a subtract in the datapath
                o_alu_op = C_ALU_SUB;
                o_class  = CLS_CBZ;
            end
            default: o_class = CLS_ALU;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/leglite_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : leglite_seq_ctrl
// Description : Multi-cycle sequencing controller for the LEGLite core.
//               FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with
//               handshaked instruction and data memory accesses and a
//               retired-instruction counter.
// Ports       : clk, rst_n (async, active low)
//               o_imem_req / i_imem_ack / i_instr  - instruction fetch
//               o_dmem_req / o_dmem_we / i_dmem_ack - data access
//               o_pc_en, o_branch                  - PC update strobes
//               o_reg_write, o_alu_src, o_alu_op, o_mem_to_reg - datapath
//               o_ir, o_state, o_instr_count       - status
// Revision    : 1.0 - initial release
// ============================================================================
module leglite_seq_ctrl
    import leglite_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic [15:0] i_instr,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ack,
    output logic        o_pc_en,
    output logic        o_branch,
    output logic        o_reg_write,
    output logic        o_alu_src,
    output logic [2:0]  o_alu_op,
    output logic        o_mem_to_reg,
    output logic [15:0] o_ir,
    output logic [2:0]  o_state,
    output logic [15:0] o_instr_count
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [15:0] r_instr_count;
    // Low while in reset and for the cycle in which reset is released, so the
    // fetch request only appears from the first full cycle after release.
    logic        r_live;

    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_pc_en;
    logic        w_branch;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_dec_mem_to_reg;
    logic [2:0]  w_alu_op;
    logic        w_alu_src;
    iclass_t     w_class;

    leglite_decode u_decode (
        .i_opcode     (r_ir[15:13]),
        .o_alu_op     (w_alu_op),
        .o_alu_src    (w_alu_src),
        .o_mem_to_reg (w_dec_mem_to_reg),
        .o_class      (w_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_ir          <= 16'h0000;
            r_instr_count <= 16'h0000;
            r_live        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;
            if (w_imem_req && i_imem_ack) begin
                r_ir <= i_instr;
            end
            if (w_pc_en) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_pc_en      = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = r_live;
                if (r_live && i_imem_ack) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC: begin
                case (w_class)
                    CLS_LD, CLS_ST: w_next_state = ST_MEM;
                    CLS_CBZ: begin
                        w_pc_en      = 1'b1;
                        w_branch     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    default: w_next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_class == CLS_ST);
                if (i_dmem_ack) begin
                    if (w_class == CLS_ST) begin
                        // A store retires in its ack cycle; this is the one
                        // strobe that must follow the ack to keep ST at 4 cycles.
                        w_pc_en      = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_pc_en      = 1'b1;
                w_mem_to_reg = w_dec_mem_to_reg;
                w_next_state = ST_FETCH;
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    assign o_imem_req    = w_imem_req;
    assign o_dmem_req    = w_dmem_req;
    assign o_dmem_we     = w_dmem_we;
    assign o_pc_en       = w_pc_en;
    assign o_branch      = w_branch;
    assign o_reg_write   = w_reg_write;
    assign o_mem_to_reg  = w_mem_to_reg;
    assign o_alu_op      = w_alu_op;
    assign o_alu_src     = w_alu_src;
    assign o_ir          = r_ir;
    assign o_state       = r_state;
    assign o_instr_count = r_instr_count;

endmodule
`default_nettype wire
